hilo_seq: RTL and testbench
===========================

# hilo_seq

Sequencer that owns all writes into the HI/LO pair of the register file. It accepts multiply, divide and move-to-HI/LO operations from the EX stage, runs multi-cycle divides and registered multiplies, holds the pipeline with a stall until the result is ready, and drives the register file's HI/LO write enables and data. It sits between EX and the register file's HI/LO write port.

## Interface
- DIV_ITERS, 32: number of divide iterations, one quotient bit per cycle.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  EX holds a valid HI/LO-writing instruction this cycle.
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are treated as NOP.
- src_a  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- src_b  in  32  rt operand: divisor or multiplier.
- flush  in  1  abort the current operation (exception or branch flush).
- stall  out  1  hold IF/ID/EX; combinational.
- busy  out  1  state is not IDLE.
- hiwe  out  1  HI write enable, one-cycle pulse, registered.
- lowe  out  1  LO write enable, one-cycle pulse, registered.
- hi_o  out  32  HI write data, registered.
- lo_o  out  32  LO write data, registered.

## Operation
- States: IDLE, MUL, DIV, DONE.
- start is sampled only in IDLE. It is ignored in MUL, DIV and DONE, because EX still presents the stalled instruction during those states.
- MTHI/MTLO in IDLE: next cycle hiwe (or lowe) = 1 with hi_o (or lo_o) = src_a. State stays IDLE. No stall.
- MULT/MULTU in IDLE:
  - IDLE→MUL. The 64-bit product of src_a × src_b (signed for MULT, unsigned for MULTU) is registered.
  - MUL→DONE.
- DIV/DIVU in IDLE with src_b ≠ 0:
  - Operands are latched. For DIV, operand magnitudes are used.
  - IDLE→DIV, iteration counter cleared.
  - Each cycle performs one restoring-divide step.
  - After DIV_ITERS steps: DIV→DONE.
  - Sign fix for DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- Divide by zero (src_b = 0): IDLE→DONE directly with LO = 32'hFFFFFFFF and HI = src_a, for both DIV and DIVU.
- DONE:
  - hiwe = lowe = 1 with HI = product[63:32] or remainder, LO = product[31:0] or quotient.
  - DONE→IDLE.
- flush: in any state, next state is IDLE with no write pulse. An in-flight result is discarded. flush has priority over start in the same cycle.
- stall = (state == IDLE & start & op ∈ {MULT, MULTU, DIV, DIVU} & ~flush) | state == MUL | state == DIV.
- Reset: state IDLE, counter 0, all outputs 0 (stall 0, busy 0, hiwe/lowe 0, hi_o/lo_o 0).

## Timing
- Start accepted at cycle N.
- MTHI/MTLO: write pulse at N+1. stall is never asserted.
- MULT/MULTU: stall high at N and N+1. DONE (write pulse) at N+2, where stall is low. The instruction leaves EX at the end of N+2. IDLE at N+3.
- DIV/DIVU: stall high N..N+DIV_ITERS. DIV state occupies N+1..N+DIV_ITERS. DONE at N+DIV_ITERS+1.
- Divide by zero: stall high at N only. DONE at N+1.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE. A write pulse is never produced in two consecutive cycles by one instruction.
- flush asserted during DIV at cycle M: busy and stall low at M+1, no write pulse.
- Asynchronous reset mid-divide: outputs go to reset values immediately, with no write pulse.

## Structure
- Package hilo_pkg holds:
  - op encodings (OP_NOP … OP_MTLO);
  - the state enum;
  - DIV_ITERS default;
  - the divide-by-zero constants.
- Sub-module hilo_div_core implements the iterative restoring divider datapath:
  - load, step and done;
  - magnitude conversion and sign fix-up.
- hilo_seq keeps the FSM, the stall logic, the multiplier register and the output registers.

## Test plan
- MULT with src_a = 0xFFFFFFFE (−2), src_b = 3: stall high 2 cycles, then hiwe = lowe = 1 with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands gives HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV with src_a = −7, src_b = 2: stall high 33 cycles, then LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 100/7 gives LO = 14, HI = 2.
- DIVU with src_b = 0, src_a = 0x1234: one stall cycle, then LO = 0xFFFFFFFF, HI = 0x1234.
- MTHI 0xDEADBEEF followed immediately by MTLO 0x0BADF00D: hiwe pulses at N+1, lowe pulses at N+2, stall stays 0 throughout.
- DIV started, flush at iteration 10: no hiwe/lowe, busy low next cycle. A MULTU started in the same cycle as a flush is not accepted.
- rst asserted at DIV iteration 20: all outputs 0 immediately. After release, MTLO 5 writes lo_o = 5 at N+1.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings, FSM state type and constants for the HI/LO write sequencer.
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_e;

    localparam int DIV_ITERS_DEF = 32;

    // Divide by zero writes all-ones to LO; HI receives the dividend unchanged.
    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative restoring divider: one quotient bit per step, on operand magnitudes,
// with the sign fix-up applied to the result of the step in progress.
module hilo_div_core
    import hilo_pkg::*;
#(
    parameter int ITERS = DIV_ITERS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        last_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    localparam int CNT_W = $clog2(ITERS + 1);

    logic [31:0]      divisor_q, divisor_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        trial    = {rem_q, quo_q[31]};
        diff     = trial - {1'b0, divisor_q};
        fits     = ~diff[32];
        rem_step = fits ? diff[31:0] : trial[31:0];
        quo_step = {quo_q[30:0], fits};
        mag_a    = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
        mag_b    = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;
    end

    // Results reflect the step being taken this cycle so the final step can be
    // captured directly into the output registers on the same edge.
    assign quo_o  = neg_quo_q ? (32'd0 - quo_step) : quo_step;
    assign rem_o  = neg_rem_q ? (32'd0 - rem_step) : rem_step;
    assign last_o = (cnt_q == CNT_W'(ITERS - 1));

    always_comb begin
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (load_i) begin
            divisor_d = mag_b;
            rem_d     = 32'd0;
            quo_d     = mag_a;
            cnt_d     = '0;
            neg_quo_d = signed_i & (a_i[31] ^ b_i[31]);
            neg_rem_d = signed_i & a_i[31];
        end else if (step_i) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/hilo_seq.sv
// HI/LO write sequencer: takes MULT/DIV/MTHI/MTLO from EX, stalls the pipe while
// a multiply or divide is in flight, and pulses registered HI/LO writes.
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hiwe,
    output logic        lowe,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Handshake: start is EX's valid. An op is taken only in an IDLE cycle with
    // start & ~flush; EX must keep presenting it while stall is high, and it
    // leaves EX at the end of the first cycle in which stall is low.

    hilo_state_e state_q, state_d;
    logic [63:0] mul_q, mul_d;
    logic        hiwe_q, hiwe_d;
    logic        lowe_q, lowe_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        div_load;
    logic        div_step;
    logic        div_last;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // The low 64 bits of the extended product are correct for both signednesses.
    always_comb begin
        mul_signed = (op == OP_MULT);
        ext_a      = {{32{mul_signed & src_a[31]}}, src_a};
        ext_b      = {{32{mul_signed & src_b[31]}}, src_b};
        product    = ext_a * ext_b;
    end

    assign accept = (state_q == ST_IDLE) && start && !flush;

    hilo_div_core #(
        .ITERS(DIV_ITERS)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .load_i  (div_load),
        .step_i  (div_step),
        .signed_i(op == OP_DIV),
        .a_i     (src_a),
        .b_i     (src_b),
        .last_o  (div_last),
        .quo_o   (div_quo),
        .rem_o   (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        mul_d    = mul_q;
        hiwe_d   = 1'b0;
        lowe_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MTHI: begin
                            hiwe_d = 1'b1;
                            hi_d   = src_a;
                        end
                        OP_MTLO: begin
                            lowe_d = 1'b1;
                            lo_d   = src_a;
                        end
                        OP_MULT, OP_MULTU: begin
                            mul_d   = product;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == 32'd0) begin
                                hiwe_d  = 1'b1;
                                lowe_d  = 1'b1;
                                hi_d    = src_a;
                                lo_d    = DIVZERO_LO;
                                state_d = ST_DONE;
                            end else begin
                                div_load = 1'b1;
                                state_d  = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                hiwe_d  = 1'b1;
                lowe_d  = 1'b1;
                hi_d    = mul_q[63:32];
                lo_d    = mul_q[31:0];
                state_d = ST_DONE;
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    hiwe_d  = 1'b1;
                    lowe_d  = 1'b1;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush discards anything in flight, including a result about to be written.
        if (flush) begin
            state_d  = ST_IDLE;
            hiwe_d   = 1'b0;
            lowe_d   = 1'b0;
            hi_d     = hi_q;
            lo_d     = lo_q;
            div_load = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mul_q   <= 64'd0;
            hiwe_q  <= 1'b0;
            lowe_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            mul_q   <= mul_d;
            hiwe_q  <= hiwe_d;
            lowe_q  <= lowe_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall = (accept && op_is_muldiv(op)) || (state_q == ST_MUL) || (state_q == ST_DIV);
    assign busy  = (state_q != ST_IDLE);
    assign hiwe  = hiwe_q;
    assign lowe  = lowe_q;
    assign hi_o  = hi_q;
    assign lo_o  = lo_q;

endmodule

// File: tb/tb_hilo_seq.sv
// Directed bench for hilo_seq: expected writes go into a queue, a monitor pops
// and compares them whenever a HI/LO write pulse appears.
module tb_hilo_seq;
  import hilo_pkg::*;

  localparam int W = 98;  // {cycle[31:0], hiwe, lowe, hi[31:0], lo[31:0]}

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        hiwe;
  logic        lowe;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [31:0]  cyc;
  int           n_checks;
  int           n_pass;

  hilo_seq dut (
    .clk  (clk),
    .rst  (rst_n),
    .start(start),
    .op   (op),
    .src_a(src_a),
    .src_b(src_b),
    .flush(flush),
    .stall(stall),
    .busy (busy),
    .hiwe (hiwe),
    .lowe (lowe),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (hiwe || lowe)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: hiwe=%0b lowe=%0b hi=0x%0h lo=0x%0h at cycle %0d, expected none",
                 hiwe, lowe, hi_o, lo_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(mon_e[97:66]));
        check("hiwe", 64'(hiwe), 64'(mon_e[65]));
        check("lowe", 64'(lowe), 64'(mon_e[64]));
        if (mon_e[65]) check("hi_o", 64'(hi_o), 64'(mon_e[63:32]));
        if (mon_e[64]) check("lo_o", 64'(lo_o), 64'(mon_e[31:0]));
      end
    end
  end

  // driver: called 1ns after a rising edge; returns 1ns after a rising edge
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stalls, input int lat,
                       input logic hw, input logic lw, input logic [31:0] ehi,
                       input logic [31:0] elo);
    int stalls;
    exp_q.push_back({cyc + 32'(lat), hw, lw, ehi, elo});
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      else break;
    end
    check({name, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NOP;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, 64'(stall), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_hiwe"}, 64'(hiwe), 64'd0);
    check({name, "_lowe"}, 64'(lowe), 64'd0);
    check({name, "_hi_o"}, 64'(hi_o), 64'd0);
    check({name, "_lo_o"}, 64'(lo_o), 64'd0);
  endtask

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000ns");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_NOP;
    src_a = 32'd0;
    src_b = 32'd0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // multiplies: 2 stall cycles, write at N+2
    do_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 2, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 2, 1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
    // divides: 33 stall cycles, write at N+33 (LO quotient, HI remainder)
    do_op("div_neg7_2", OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 33, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 33, 1'b1, 1'b1, 32'd2, 32'd14);
    do_op("div_7_neg2", OP_DIV,  32'd7, 32'hFFFF_FFFE, 33, 33, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFD);
    do_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 33, 1'b1, 1'b1, 32'd0, 32'h8000_0000);
    // divide by zero: one stall cycle, write at N+1
    do_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1, 1, 1'b1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
    do_op("div_zero",  OP_DIV,  32'hFFFF_FFF0, 32'd0, 1, 1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    // back-to-back moves: no stall, pulses at N+1 and N+2
    do_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
    do_op("mtlo", OP_MTLO, 32'h0BAD_F00D, 32'd0, 0, 1, 1'b0, 1'b1, 32'd0, 32'h0BAD_F00D);

    // flush at divide iteration 10: no write, idle next cycle
    start = 1'b1;
    op    = OP_DIV;
    src_a = 32'd100;
    src_b = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    op    = OP_NOP;
    @(negedge clk);
    check("flush_div_busy_after", 64'(busy), 64'd0);
    check("flush_div_stall_after", 64'(stall), 64'd0);

    // MULTU presented together with flush is not accepted
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_MULTU;
    src_a = 32'd3;
    src_b = 32'd4;
    flush = 1'b1;
    @(negedge clk);
    check("flush_multu_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NOP;
    flush = 1'b0;
    @(negedge clk);
    check("flush_multu_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // asynchronous reset at divide iteration 20
    start = 1'b1;
    op    = OP_DIV;
    src_a = 32'hFFFF_FFF9;
    src_b = 32'd2;
    repeat (21) @(posedge clk);
    #3;
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_NOP;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("mtlo_after_reset", OP_MTLO, 32'd5, 32'd0, 0, 1, 1'b0, 1'b1, 32'd0, 32'd5);

    repeat (40) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
